axil_ram_slave: RTL and testbench

AXI4-Lite slave backed by an internal word-organised RAM. Accepts single-beat writes (with byte strobes) and reads from an AXI4-Lite master. Used as the memory endpoint behind the HLS write/read handler logic. Always returns OKAY responses; there are no bursts and no error responses.

---
 rtl/axil_ram_slave_pkg.sv | 12 +
 rtl/axil_ram_core.sv | 51 +++++
 rtl/axil_ram_slave.sv | 103 ++++++++++
 tb/tb_axil_ram_slave.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_ram_slave_pkg.sv
// Shared constants and helpers for the AXI4-Lite RAM slave.
// Both the top-level handshake logic and the RAM core import this package.
package axil_ram_slave_pkg;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Number of byte-offset bits dropped when turning a byte address into a word index.
    function automatic int word_shift(input int strb_width);
        return $clog2(strb_width);
    endfunction

endpackage

// File: rtl/axil_ram_core.sv
// Single-clock RAM with one byte-enabled write port and one registered read port.
// A read and a write to the same word in one cycle return the old contents.
module axil_ram_core
    import axil_ram_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int WORD_AW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [WORD_AW-1:0]    i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [STRB_WIDTH-1:0] i_wstrb,
    input  logic                  i_re,
    input  logic [WORD_AW-1:0]    i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 2 ** WORD_AW;

    // Contents start at zero at power-up and survive rst.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-lane write port
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_waddr][i*8 +: 8] <= i_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Registered read port; holds its value until the next read enable
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else begin
            r_rdata <= r_rdata;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axil_ram_slave.sv
// AXI4-Lite slave in front of a word-organised RAM: single-beat writes with
// byte strobes, one-cycle-latency reads, always OKAY responses.
module axil_ram_slave
    import axil_ram_slave_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int WORD_LSB = word_shift(STRB_WIDTH);
    localparam int WORD_AW  = ADDR_WIDTH - WORD_LSB;

    logic               w_wr_fire;
    logic               w_rd_fire;
    logic [WORD_AW-1:0] w_wr_word;
    logic [WORD_AW-1:0] w_rd_word;
    logic               r_bvalid;
    logic               r_rvalid;
    logic               w_unused;

    // AW and W are only ever accepted together; readies stay low during rst.
    assign w_wr_fire = !rst && s_axil_awvalid && s_axil_wvalid && (!r_bvalid || s_axil_bready);
    assign w_rd_fire = !rst && s_axil_arvalid && (!r_rvalid || s_axil_rready);

    assign w_wr_word = s_axil_awaddr[ADDR_WIDTH-1:WORD_LSB];
    assign w_rd_word = s_axil_araddr[ADDR_WIDTH-1:WORD_LSB];

    assign w_unused = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr, s_axil_araddr};

    // Write response valid: set on a fire, cleared once the master takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bvalid <= 1'b0;
        end else if (w_wr_fire) begin
            r_bvalid <= 1'b1;
        end else if (s_axil_bready) begin
            r_bvalid <= 1'b0;
        end else begin
            r_bvalid <= r_bvalid;
        end
    end

    // Read data valid: set on a fire, cleared once the master takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
        end else if (w_rd_fire) begin
            r_rvalid <= 1'b1;
        end else if (s_axil_rready) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= r_rvalid;
        end
    end

    axil_ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .STRB_WIDTH (STRB_WIDTH),
        .WORD_AW    (WORD_AW)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_fire),
        .i_waddr (w_wr_word),
        .i_wdata (s_axil_wdata),
        .i_wstrb (s_axil_wstrb),
        .i_re    (w_rd_fire),
        .i_raddr (w_rd_word),
        .o_rdata (s_axil_rdata)
    );

    assign s_axil_awready = w_wr_fire;
    assign s_axil_wready  = w_wr_fire;
    assign s_axil_arready = w_rd_fire;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_bresp   = RESP_OKAY;
    assign s_axil_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axil_ram_slave.sv
// Self-checking bench for axil_ram_slave: a word model predicts read data,
// expected values are queued when a read fires and popped when data returns.
module tb_axil_ram_slave;

    logic        clk;
    logic        rst;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int          n_checks;
    int          n_fail;
    logic [31:0] exp_q [$];
    logic [31:0] model [8];
    logic [31:0] exp_v;

    axil_ram_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5),
        .STRB_WIDTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    function automatic void model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) model[a[4:2]][i*8 +: 8] = d[i*8 +: 8];
        end
    endfunction

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int t;
        t = 0;
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        while (!(awready && wready) && t < 20) begin
            @(negedge clk); #1; t++;
        end
        n_checks++;
        if (t >= 20) begin
            n_fail++;
            $display("FAIL write_timeout addr=%0d: awready=%b wready=%b, required 1", a, awready, wready);
        end else begin
            model_write(a, d, s);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
    endtask

    task automatic issue_read(input logic [4:0] a);
        int t;
        t = 0;
        @(negedge clk);
        araddr = a; arvalid = 1'b1;
        #1;
        while (!arready && t < 20) begin
            @(negedge clk); #1; t++;
        end
        n_checks++;
        if (t >= 20) begin
            n_fail++;
            $display("FAIL read_timeout addr=%0d: arready=%b, required 1", a, arready);
        end else begin
            exp_q.push_back(model[a[4:2]]);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bvalid, rvalid, awready, wready, arready} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_ctrl: bv/rv/awr/wr/arr=%b, required 00000", {bvalid, rvalid, awready, wready, arready});
        end
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h, required 00000000", rdata);
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_write_basic;
        @(negedge clk);
        bready = 1'b1;
        awaddr = 5'd1; wdata = 32'd2345; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        #1;
        n_checks++;
        if (!(awready === 1'b1 && wready === 1'b1)) begin
            n_fail++;
            $display("FAIL write_ready: awready=%b wready=%b, required 1 1", awready, wready);
        end else begin
            model_write(5'd1, 32'd2345, 4'hF);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL write_bresp: bvalid=%b bresp=%b, required 1 00", bvalid, bresp);
        end
        @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL write_bclear: bvalid=%b, required 0", bvalid);
        end
    endtask

    task automatic test_read_basic;
        @(negedge clk);
        rready = 1'b1;
        issue_read(5'd1);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rresp !== 2'b00 || rdata !== exp_v || rdata !== 32'd2345) begin
            n_fail++;
            $display("FAIL read_addr1: rvalid=%b rresp=%b rdata=%0d, required 1 00 2345", rvalid, rresp, rdata);
        end
        issue_read(5'd4);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== exp_v || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL read_unwritten: rvalid=%b rdata=%h, required 1 00000000", rvalid, rdata);
        end
        @(negedge clk);
        n_checks++;
        if (rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rclear: rvalid=%b, required 0", rvalid);
        end
    endtask

    task automatic test_partial_strobe;
        do_write(5'd8, 32'hAABBCCDD, 4'hF);
        do_write(5'd8, 32'h11223344, 4'b0101);
        issue_read(5'd8);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rdata !== exp_v || rdata !== 32'hAA22CC44) begin
            n_fail++;
            $display("FAIL partial_strobe: rdata=%h, required aa22cc44", rdata);
        end
    endtask

    task automatic test_b_backpressure;
        @(negedge clk);
        bready = 1'b0;
        do_write(5'd12, 32'h5555_0001, 4'hF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            awaddr = 5'd16; wdata = 32'h0BAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
            #1;
            n_checks++;
            if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_write_stall cyc=%0d: awready=%b wready=%b bvalid=%b, required 0 0 1", c, awready, wready, bvalid);
            end
        end
        @(negedge clk);
        bready = 1'b1;
        #1;
        n_checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_write_release: awready=%b wready=%b, required 1 1", awready, wready);
        end else begin
            model_write(5'd16, 32'h0BAD_BEEF, 4'hF);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_second_bvalid: bvalid=%b, required 1", bvalid);
        end
        issue_read(5'd16);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rdata !== exp_v || rdata !== 32'h0BAD_BEEF) begin
            n_fail++;
            $display("FAIL bp_second_data: rdata=%h, required 0badbeef", rdata);
        end
    endtask

    task automatic test_r_backpressure;
        @(negedge clk);
        rready = 1'b0;
        issue_read(5'd12);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            araddr = 5'd16; arvalid = 1'b1;
            #1;
            n_checks++;
            if (arready !== 1'b0 || rvalid !== 1'b1 || rdata !== exp_q[0]) begin
                n_fail++;
                $display("FAIL bp_read_hold cyc=%0d: arready=%b rvalid=%b rdata=%h, required 0 1 %h", c, arready, rvalid, rdata, exp_q[0]);
            end
        end
        @(negedge clk);
        rready = 1'b1;
        #1;
        exp_v = exp_q.pop_front();
        n_checks++;
        if (arready !== 1'b1 || rdata !== exp_v || rdata !== 32'h5555_0001) begin
            n_fail++;
            $display("FAIL bp_read_release: arready=%b rdata=%h, required 1 55550001", arready, rdata);
        end else begin
            exp_q.push_back(model[4]);
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rvalid !== 1'b1 || rdata !== exp_v) begin
            n_fail++;
            $display("FAIL bp_read_second: rvalid=%b rdata=%h, required 1 %h", rvalid, rdata, exp_v);
        end
    endtask

    task automatic test_channel_independence;
        @(negedge clk);
        bready = 1'b1;
        awaddr = 5'd20; wdata = 32'h1357_9BDF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL aw_only cyc=%0d: awready=%b wready=%b bvalid=%b, required 0 0 0", c, awready, wready, bvalid);
            end
            @(negedge clk);
        end
        wvalid = 1'b1;
        #1;
        n_checks++;
        if (awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL aw_then_w: awready=%b wready=%b, required 1 1", awready, wready);
        end else begin
            model_write(5'd20, 32'h1357_9BDF, 4'hF);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL aw_then_w_bvalid: bvalid=%b, required 1", bvalid);
        end
        issue_read(5'd20);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rdata !== exp_v || rdata !== 32'h1357_9BDF) begin
            n_fail++;
            $display("FAIL aw_then_w_data: rdata=%h, required 13579bdf", rdata);
        end
    endtask

    task automatic test_same_cycle_rw;
        @(negedge clk);
        bready = 1'b1; rready = 1'b1;
        awaddr = 5'd1; wdata = 32'd7; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 5'd1; arvalid = 1'b1;
        #1;
        n_checks++;
        if (arready !== 1'b1 || awready !== 1'b1 || wready !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_ready: arready=%b awready=%b wready=%b, required 1 1 1", arready, awready, wready);
        end else begin
            exp_q.push_back(model[0]);
            model_write(5'd1, 32'd7, 4'hF);
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rdata !== exp_v || rdata !== 32'd2345) begin
            n_fail++;
            $display("FAIL same_cycle_old: rdata=%0d, required 2345", rdata);
        end
        issue_read(5'd1);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rdata !== exp_v || rdata !== 32'd7) begin
            n_fail++;
            $display("FAIL same_cycle_new: rdata=%0d, required 7", rdata);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        do_write(5'd28, 32'hCAFE_F00D, 4'hF);
        issue_read(5'd24);
        exp_q.delete();
        @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_pending: bvalid=%b rvalid=%b, required 1 1", bvalid, rvalid);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_reset_drop: bvalid=%b rvalid=%b rdata=%h, required 0 0 00000000", bvalid, rvalid, rdata);
        end
        rst = 1'b0; bready = 1'b1; rready = 1'b1;
        issue_read(5'd1);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rdata !== exp_v || rdata !== 32'd7) begin
            n_fail++;
            $display("FAIL post_reset_addr1: rdata=%0d, required 7", rdata);
        end
        issue_read(5'd28);
        @(negedge clk);
        exp_v = exp_q.pop_front();
        n_checks++;
        if (rdata !== exp_v || rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL post_reset_addr28: rdata=%h, required cafef00d", rdata);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        rst = 1'b1;
        awaddr = 5'd0; awprot = 3'd0; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0; bready = 1'b0;
        araddr = 5'd0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;

        test_reset();
        test_write_basic();
        test_read_basic();
        test_partial_strobe();
        test_b_backpressure();
        test_r_backpressure();
        test_channel_independence();
        test_same_cycle_rw();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
